// File: rtl/instr_reg_scheduler_if.sv
// Types shared with instr_register, plus the scheduler's bus interface.
//   slave  : scheduler side (requester handshakes in, register-file
//            write/read controls out, response port out, occupancy out)
//   master : environment side (requesters, register file, consumer)
package instr_register_pkg;
  typedef enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD} opcode_t;
  typedef logic signed [31:0] operand_t;
  typedef logic signed [63:0] result_t;
  typedef logic [4:0]         address_t;
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rezultat;
  } instruction_t;
endpackage

interface instr_reg_scheduler_if;
  import instr_register_pkg::*;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  opcode_t      req0_opcode, req1_opcode;
  operand_t     req0_operand_a, req0_operand_b, req1_operand_a, req1_operand_b;
  logic         load_en;
  opcode_t      opcode;
  operand_t     operand_a, operand_b;
  address_t     write_pointer, read_pointer;
  instruction_t instruction_word;
  logic         rsp_valid, rsp_ready, rsp_src;
  instruction_t rsp_instruction;
  logic [5:0]   count;
  logic         full, empty;

  modport slave (
    input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
    input  req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
    output req0_ready, req1_ready,
    output load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
    input  instruction_word,
    output rsp_valid, rsp_instruction, rsp_src,
    input  rsp_ready,
    output count, full, empty
  );

  modport master (
    output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
    output req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
    input  req0_ready, req1_ready,
    input  load_en, opcode, operand_a, operand_b, write_pointer, read_pointer,
    output instruction_word,
    input  rsp_valid, rsp_instruction, rsp_src,
    output rsp_ready,
    input  count, full, empty
  );
endinterface

// File: rtl/instr_reg_scheduler.sv
// Write-port arbiter and read-back sequencer for instr_register.
// Two requesters are granted round-robin; each accept is registered onto the
// register-file write port and tracked in a circular FIFO over the 32 entries.
// Written entries are returned in write order on the response port with the
// issuing requester's ID.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : requester handshakes, register-file controls, response
//                  port, count/full/empty
module instr_reg_scheduler #(
  parameter int DEPTH = 32
) (
  input logic                  clk,
  input logic                  reset_n,
  instr_reg_scheduler_if.slave bus
);
  import instr_register_pkg::*;

  logic             last;       // most recently granted requester
  address_t         wr_ptr, rd_ptr;
  logic [5:0]       count_q;    // reserved entries (accepted, not popped)
  logic [5:0]       committed;  // written into instr_register, not popped
  logic [DEPTH-1:0] tag;        // source requester per entry
  logic             load_en_q;
  opcode_t          opcode_q;
  operand_t         operand_a_q, operand_b_q;
  address_t         write_pointer_q;

  logic win0, win1, full_w, acc0, acc1, acc, pop;

  always_comb begin
    win0   = bus.req0_valid && (!bus.req1_valid || last);
    win1   = !win0 && bus.req1_valid;
    full_w = (count_q == 6'(DEPTH));
    acc0   = win0 && !full_w;
    acc1   = win1 && !full_w;
    acc    = acc0 || acc1;
    pop    = (committed != 6'd0) && bus.rsp_ready;
  end

  assign bus.req0_ready      = acc0;
  assign bus.req1_ready      = acc1;
  assign bus.load_en         = load_en_q;
  assign bus.opcode          = opcode_q;
  assign bus.operand_a       = operand_a_q;
  assign bus.operand_b       = operand_b_q;
  assign bus.write_pointer   = write_pointer_q;
  assign bus.read_pointer    = rd_ptr;
  assign bus.rsp_valid       = (committed != 6'd0);
  assign bus.rsp_instruction = bus.instruction_word;
  assign bus.rsp_src         = tag[rd_ptr];
  assign bus.count           = count_q;
  assign bus.full            = full_w;
  assign bus.empty           = (count_q == 6'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last            <= 1'b1;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count_q         <= '0;
      committed       <= '0;
      tag             <= '0;
      load_en_q       <= 1'b0;
      opcode_q        <= ZERO;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      write_pointer_q <= '0;
    end else begin
      load_en_q <= acc;
      if (acc) begin
        last            <= acc1;
        opcode_q        <= acc1 ? bus.req1_opcode    : bus.req0_opcode;
        operand_a_q     <= acc1 ? bus.req1_operand_a : bus.req0_operand_a;
        operand_b_q     <= acc1 ? bus.req1_operand_b : bus.req0_operand_b;
        write_pointer_q <= wr_ptr;
        tag[wr_ptr]     <= acc1;
        wr_ptr          <= (wr_ptr == address_t'(DEPTH-1)) ? '0 : wr_ptr + address_t'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == address_t'(DEPTH-1)) ? '0 : rd_ptr + address_t'(1);
      // Same-edge increment and decrement cancel out.
      count_q   <= count_q + 6'(acc) - 6'(pop);
      // load_en marks the edge on which instr_register performs the write.
      committed <= committed + 6'(load_en_q) - 6'(pop);
    end
  end
endmodule

// File: tb/tb_instr_reg_scheduler.sv
module tb_instr_reg_scheduler;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  instr_reg_scheduler_if bus ();
  instr_reg_scheduler dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  // Behavioural instr_register: writes on load_en, combinational read.
  function automatic result_t calc(opcode_t o, operand_t a, operand_t b);
    case (o)
      ZERO:    return '0;
      PASSA:   return result_t'(a);
      PASSB:   return result_t'(b);
      ADD:     return result_t'(a) + result_t'(b);
      SUB:     return result_t'(a) - result_t'(b);
      MULT:    return result_t'(a) * result_t'(b);
      DIV:     return (b == 0) ? '0 : result_t'(a / b);
      MOD:     return (b == 0) ? '0 : result_t'(a % b);
      default: return 'x;
    endcase
  endfunction

  instruction_t mem [32];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (bus.load_en) begin
      mem[bus.write_pointer] <= '{opc: bus.opcode, op_a: bus.operand_a, op_b: bus.operand_b,
                                  rezultat: calc(bus.opcode, bus.operand_a, bus.operand_b)};
    end
  end
  assign bus.instruction_word = mem[bus.read_pointer];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req0(input logic v, input opcode_t o, input int a, input int b);
    bus.req0_valid = v; bus.req0_opcode = o; bus.req0_operand_a = a; bus.req0_operand_b = b;
  endtask

  task automatic set_req1(input logic v, input opcode_t o, input int a, input int b);
    bus.req1_valid = v; bus.req1_opcode = o; bus.req1_operand_a = a; bus.req1_operand_b = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_req0(1'b0, ZERO, 0, 0);
    set_req1(1'b0, ZERO, 0, 0);
    bus.rsp_ready = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_req0(1'b0, ZERO, 0, 0);
    set_req1(1'b0, ZERO, 0, 0);
    bus.rsp_ready = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_load_en", 64'(bus.load_en), 0);
    chk("rst_opcode",  64'(bus.opcode), 64'(ZERO));
    chk("rst_wp",      64'(bus.write_pointer), 0);
    chk("rst_rp",      64'(bus.read_pointer), 0);
    chk("rst_count",   64'(bus.count), 0);
    chk("rst_full",    64'(bus.full), 0);
    chk("rst_empty",   64'(bus.empty), 1);
    chk("rst_rsp_vld", 64'(bus.rsp_valid), 0);
    chk("rst_rsp_src", 64'(bus.rsp_src), 0);
    reset_n = 1'b1;

    // Single request: ADD 5+3
    set_req0(1'b1, ADD, 5, 3);
    bus.rsp_ready = 1'b1;
    #1;
    chk("single_rdy0", 64'(bus.req0_ready), 1);
    chk("single_rdy1", 64'(bus.req1_ready), 0);
    tick();
    bus.req0_valid = 1'b0;
    chk("single_load_en", 64'(bus.load_en), 1);
    chk("single_wp",      64'(bus.write_pointer), 0);
    chk("single_count",   64'(bus.count), 1);
    chk("single_no_rsp",  64'(bus.rsp_valid), 0);
    tick();
    chk("single_load_off", 64'(bus.load_en), 0);
    chk("single_rsp_vld",  64'(bus.rsp_valid), 1);
    chk("single_result",   64'(bus.rsp_instruction.rezultat), 8);
    chk("single_src",      64'(bus.rsp_src), 0);
    tick();
    chk("single_drained", 64'(bus.rsp_valid), 0);
    chk("single_count0",  64'(bus.count), 0);
    chk("single_empty",   64'(bus.empty), 1);
    chk("single_rp",      64'(bus.read_pointer), 1);

    // Round-robin: req0 ADD 1+1 = 2, req1 SUB 9-4 = 5
    do_reset();
    set_req0(1'b1, ADD, 1, 1);
    set_req1(1'b1, SUB, 9, 4);
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_rdy0", 64'(bus.req0_ready), 64'(i % 2 == 0));
      chk("rr_rdy1", 64'(bus.req1_ready), 64'(i % 2 == 1));
      if (i > 0) chk("rr_wp", 64'(bus.write_pointer), 64'(i - 1));
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("rr_wp_last", 64'(bus.write_pointer), 5);
    chk("rr_count",   64'(bus.count), 6);
    tick();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_rsp_vld", 64'(bus.rsp_valid), 1);
      chk("rr_rsp_src", 64'(bus.rsp_src), 64'(k % 2));
      chk("rr_result",  64'(bus.rsp_instruction.rezultat), (k % 2 == 0) ? 64'd2 : 64'd5);
      tick();
    end
    chk("rr_drained", 64'(bus.rsp_valid), 0);
    chk("rr_count0",  64'(bus.count), 0);
    bus.rsp_ready = 1'b0;

    // Full and wrap
    do_reset();
    set_req0(1'b1, ADD, 3, 4);
    repeat (32) tick();
    chk("full_count", 64'(bus.count), 32);
    chk("full_flag",  64'(bus.full), 1);
    chk("full_rdy0",  64'(bus.req0_ready), 0);
    chk("full_wp31",  64'(bus.write_pointer), 31);
    bus.req1_valid = 1'b1;
    #1;
    chk("full_rdy1", 64'(bus.req1_ready), 0);
    bus.req1_valid = 1'b0;
    tick();
    chk("full_stall_load", 64'(bus.load_en), 0);
    chk("full_stall_count", 64'(bus.count), 32);
    bus.rsp_ready = 1'b1;
    #1;
    chk("full_rsp_vld", 64'(bus.rsp_valid), 1);
    chk("full_rp0",     64'(bus.read_pointer), 0);
    chk("full_pop_rdy", 64'(bus.req0_ready), 0);
    tick();
    bus.rsp_ready = 1'b0;
    #1;
    chk("full_after_pop_rdy", 64'(bus.req0_ready), 1);
    chk("full_after_pop_cnt", 64'(bus.count), 31);
    chk("full_rp1",           64'(bus.read_pointer), 1);
    tick();
    bus.req0_valid = 1'b0;
    chk("wrap_load_en", 64'(bus.load_en), 1);
    chk("wrap_wp0",     64'(bus.write_pointer), 0);
    chk("wrap_count",   64'(bus.count), 32);
    chk("wrap_full",    64'(bus.full), 1);

    // Simultaneous accept and pop at count 5
    do_reset();
    set_req0(1'b1, ADD, 1, 2);
    repeat (5) tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("sim_pre_count", 64'(bus.count), 5);
    chk("sim_pre_rp",    64'(bus.read_pointer), 0);
    bus.req0_valid = 1'b1;
    bus.rsp_ready  = 1'b1;
    #1;
    chk("sim_rdy",     64'(bus.req0_ready), 1);
    chk("sim_rsp_vld", 64'(bus.rsp_valid), 1);
    tick();
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    chk("sim_count", 64'(bus.count), 5);
    chk("sim_rp",    64'(bus.read_pointer), 1);
    chk("sim_wp",    64'(bus.write_pointer), 5);

    // Pass-through results: DIV 7/0 -> 0, MOD 7%3 -> 1
    do_reset();
    set_req0(1'b1, DIV, 7, 0);
    tick();
    set_req0(1'b1, MOD, 7, 3);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.rsp_ready = 1'b1;
    #1;
    chk("div_opc",    64'(bus.rsp_instruction.opc), 64'(DIV));
    chk("div_result", 64'(bus.rsp_instruction.rezultat), 0);
    tick();
    chk("mod_opc",    64'(bus.rsp_instruction.opc), 64'(MOD));
    chk("mod_result", 64'(bus.rsp_instruction.rezultat), 1);
    tick();
    chk("pt_drained", 64'(bus.rsp_valid), 0);
    bus.rsp_ready = 1'b0;

    // Reset mid-operation: 3 entries unread, 4th load pending
    do_reset();
    set_req1(1'b1, PASSA, 42, 0);
    repeat (4) tick();
    bus.req1_valid = 1'b0;
    chk("mid_pre_load_en", 64'(bus.load_en), 1);
    chk("mid_pre_count",   64'(bus.count), 4);
    reset_n = 1'b0;
    #1;
    chk("mid_load_en", 64'(bus.load_en), 0);
    chk("mid_count",   64'(bus.count), 0);
    chk("mid_rsp_vld", 64'(bus.rsp_valid), 0);
    chk("mid_empty",   64'(bus.empty), 1);
    chk("mid_wp",      64'(bus.write_pointer), 0);
    chk("mid_rsp_src", 64'(bus.rsp_src), 0);
    tick();
    reset_n = 1'b1;
    repeat (3) begin
      tick();
      chk("mid_no_rsp", 64'(bus.rsp_valid), 0);
    end
    set_req0(1'b1, ADD, 20, 22);
    #1;
    chk("mid_new_rdy", 64'(bus.req0_ready), 1);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk("mid_new_rsp",    64'(bus.rsp_valid), 1);
    chk("mid_new_result", 64'(bus.rsp_instruction.rezultat), 42);
    chk("mid_new_src",    64'(bus.rsp_src), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
